// File: rtl/mem_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_rr_if
// Brief  : Requester-side and memory-side bus bundle of the N-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_rr_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int N_PORTS    = 4,
  parameter int MAX_OUTST  = 4
);
  localparam int c_CNT_W = $clog2(MAX_OUTST) + 1;

  logic [N_PORTS*ADDR_WIDTH-1:0] p_address;
  logic [N_PORTS*BE_WIDTH-1:0]   p_byteenable;
  logic [N_PORTS-1:0]            p_read;
  logic [N_PORTS-1:0]            p_write;
  logic [N_PORTS*DATA_WIDTH-1:0] p_writedata;
  logic [N_PORTS-1:0]            p_waitrequest;
  logic [DATA_WIDTH-1:0]         p_readdata;
  logic [N_PORTS-1:0]            p_readdataready;

  logic [ADDR_WIDTH-1:0]         mem_address;
  logic [BE_WIDTH-1:0]           mem_byteenable;
  logic                          mem_read;
  logic                          mem_write;
  logic [DATA_WIDTH-1:0]         mem_writedata;
  logic                          mem_waitrequest;
  logic [DATA_WIDTH-1:0]         mem_readdata;
  logic                          mem_readdataready;

  logic [c_CNT_W-1:0]            outstanding;
  logic                          err_orphan;
  logic                          err_rdwr;

  // Environment view: requesters plus the external memory.
  modport master (
    output p_address, p_byteenable, p_read, p_write, p_writedata,
    output mem_waitrequest, mem_readdata, mem_readdataready,
    input  p_waitrequest, p_readdata, p_readdataready,
    input  mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
    input  outstanding, err_orphan, err_rdwr
  );

  // Arbiter view.
  modport slave (
    input  p_address, p_byteenable, p_read, p_write, p_writedata,
    input  mem_waitrequest, mem_readdata, mem_readdataready,
    output p_waitrequest, p_readdata, p_readdataready,
    output mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
    output outstanding, err_orphan, err_rdwr
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_rr
// Brief  : N-port round-robin / fixed-priority memory arbiter with read-ID FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int N_PORTS    = 4,
  parameter int MAX_OUTST  = 4,
  parameter int PRIO_MODE  = 0
) (
  input  wire logic       clock,
  input  wire logic       reset,
  mem_arbiter_rr_if.slave bus
);
  localparam int c_IDX_W = $clog2(N_PORTS);
  localparam int c_PTR_W = $clog2(MAX_OUTST);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [N_PORTS-1:0] c_ONE = {{(N_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IDX_W-1:0] r_grant;
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [c_IDX_W-1:0] r_id_fifo [MAX_OUTST];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_err_orphan;
  logic               r_err_rdwr;

  logic               w_rd_blocked;
  logic [N_PORTS-1:0] w_req;
  logic [c_IDX_W-1:0] w_winner;
  logic               w_g_read;
  logic               w_g_write;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_IDX_W-1:0] f_rr_idx(input logic [c_IDX_W-1:0] ptr, input int k);
    int t;
    t = int'(ptr) + k;
    if (t >= N_PORTS) t = t - N_PORTS;
    return c_IDX_W'(t);
  endfunction

  assign w_rd_blocked = (r_count == c_CNT_W'(MAX_OUTST));
  assign w_req        = bus.p_write | (bus.p_read & {N_PORTS{~w_rd_blocked}});

  // Scan from the far end so the last hit is the highest-priority requester.
  always_comb begin
    w_winner = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (PRIO_MODE != 0) begin
        if (w_req[k-1]) w_winner = c_IDX_W'(k - 1);
      end else begin
        if (w_req[f_rr_idx(r_rr_ptr, k)]) w_winner = f_rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_g_read    = bus.p_read[r_grant];
  assign w_g_write   = bus.p_write[r_grant];
  assign w_mem_write = (r_state == S_GRANT) & w_g_write;
  assign w_mem_read  = (r_state == S_GRANT) & w_g_read & ~w_g_write & ~w_rd_blocked;
  assign w_accept    = (w_mem_read | w_mem_write) & ~bus.mem_waitrequest;
  assign w_push      = w_mem_read & ~bus.mem_waitrequest;
  assign w_pop       = bus.mem_readdataready & (r_count != '0);

  assign bus.mem_read        = w_mem_read;
  assign bus.mem_write       = w_mem_write;
  assign bus.mem_address     = bus.p_address[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_byteenable  = bus.p_byteenable[int'(r_grant)*BE_WIDTH +: BE_WIDTH];
  assign bus.mem_writedata   = bus.p_writedata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.p_waitrequest   = w_accept ? ~(c_ONE << r_grant) : '1;
  assign bus.p_readdata      = bus.mem_readdata;
  assign bus.p_readdataready = w_pop ? (c_ONE << r_id_fifo[r_rd_ptr]) : '0;
  assign bus.outstanding     = r_count;
  assign bus.err_orphan      = r_err_orphan;
  assign bus.err_rdwr        = r_err_rdwr;

  always_ff @(posedge clock) begin
    if (w_push) r_id_fifo[r_wr_ptr] <= r_grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= c_IDX_W'(N_PORTS - 1);
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
      r_err_rdwr   <= 1'b0;
    end else begin
      if ((bus.p_read & bus.p_write) != '0) r_err_rdwr <= 1'b1;
      if (bus.mem_readdataready && (r_count == '0)) r_err_orphan <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE: begin
          if (w_req != '0) begin
            r_grant <= w_winner;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A withdrawn request abandons the grant without a bus command.
          if (w_accept) begin
            r_rr_ptr <= r_grant;
            r_state  <= S_IDLE;
          end else if (!(w_mem_read || w_mem_write)) begin
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arbiter_rr
// Brief  : Randomized + directed self-checking bench for mem_arbiter_rr.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int NP = 4;
  localparam int MO = 4;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_en  = 0;

  mem_arbiter_rr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .N_PORTS(NP), .MAX_OUTST(MO)) irr ();
  mem_arbiter_rr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .N_PORTS(NP), .MAX_OUTST(MO)) ifx ();

  mem_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .N_PORTS(NP), .MAX_OUTST(MO), .PRIO_MODE(0))
    dut_rr (.clock(clk), .reset(rst), .bus(irr));
  mem_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .N_PORTS(NP), .MAX_OUTST(MO), .PRIO_MODE(1))
    dut_fx (.clock(clk), .reset(rst), .bus(ifx));

  // The fixed-priority instance sees the same requesters and a memory that never stalls.
  assign ifx.p_address         = irr.p_address;
  assign ifx.p_byteenable      = irr.p_byteenable;
  assign ifx.p_read            = irr.p_read;
  assign ifx.p_write           = irr.p_write;
  assign ifx.p_writedata       = irr.p_writedata;
  assign ifx.mem_waitrequest   = 1'b0;
  assign ifx.mem_readdata      = '0;
  assign ifx.mem_readdataready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    if (a == 20'hA) return 16'h1111;
    if (a == 20'hB) return 16'h3333;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic int oh_idx(input logic [NP-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- reference model (round-robin instance) ----------------
  bit            m_granted = 0;
  int            m_grant   = 0;
  int            m_rr      = NP - 1;
  int            m_q[$];
  bit            m_err_orphan = 0;
  bit            m_err_rdwr   = 0;
  bit            e_blk, e_r, e_w, e_acc, e_pop;
  logic [NP-1:0] e_wait, e_rdr, e_req;
  int            win, idx;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_blk = (m_q.size() == MO);
        e_r = 0;
        e_w = 0;
        if (m_granted) begin
          e_w = irr.p_write[m_grant];
          e_r = irr.p_read[m_grant] && !e_w && !e_blk;
        end
        e_acc  = (e_r || e_w) && !irr.mem_waitrequest;
        e_wait = '1;
        if (e_acc) e_wait[m_grant] = 1'b0;
        e_pop  = irr.mem_readdataready && (m_q.size() != 0);
        e_rdr  = '0;
        if (e_pop) e_rdr[m_q[0]] = 1'b1;

        check("mem_read", irr.mem_read, e_r);
        check("mem_write", irr.mem_write, e_w);
        check("p_waitrequest", irr.p_waitrequest, e_wait);
        check("p_readdataready", irr.p_readdataready, e_rdr);
        check("p_readdata", irr.p_readdata, irr.mem_readdata);
        check("outstanding", irr.outstanding, m_q.size());
        check("err_orphan", irr.err_orphan, m_err_orphan);
        check("err_rdwr", irr.err_rdwr, m_err_rdwr);
        if (e_r || e_w) begin
          check("mem_address", irr.mem_address, irr.p_address[m_grant*AW +: AW]);
          check("mem_byteenable", irr.mem_byteenable, irr.p_byteenable[m_grant*BW +: BW]);
        end
        if (e_w) check("mem_writedata", irr.mem_writedata, irr.p_writedata[m_grant*DW +: DW]);

        if (rst) begin
          m_granted = 0;
          m_grant   = 0;
          m_rr      = NP - 1;
          m_q.delete();
          m_err_orphan = 0;
          m_err_rdwr   = 0;
        end else begin
          if ((irr.p_read & irr.p_write) != '0) m_err_rdwr = 1;
          if (irr.mem_readdataready && m_q.size() == 0) m_err_orphan = 1;
          if (e_pop) void'(m_q.pop_front());
          if (e_acc && e_r) m_q.push_back(m_grant);
          if (!m_granted) begin
            e_req = irr.p_write | (irr.p_read & {NP{!e_blk}});
            win = -1;
            for (int k = 0; k < NP; k++) begin
              idx = (m_rr + 1 + k) % NP;
              if (win < 0 && e_req[idx]) win = idx;
            end
            if (win >= 0) begin
              m_granted = 1;
              m_grant   = win;
            end
          end else if (e_acc || !(e_r || e_w)) begin
            if (e_acc) m_rr = m_grant;
            m_granted = 0;
          end
        end
      end
    end
  end

  // ---------------- memory responder and cycle helper ----------------
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t pend[$];
  int   last_due = 0;
  int   lat = 3;
  int   stall_pct = 0;
  bit   force_stall = 0;
  bit   inject_orphan = 0;

  logic [NP-1:0] acc_v, rdr_v, fx_acc_v, wait_v;
  logic [DW-1:0] rdata_v, mwd_v;
  logic [AW-1:0] maddr_v;
  logic [2:0]    outst_v;
  logic          err_orph_v, err_rdwr_v, mw_v, mr_v;
  int            obs_cyc;

  task automatic tick();
    int d;
    @(negedge clk);
    if (irr.mem_read && !irr.mem_waitrequest) begin
      d = cyc + lat + 1;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{d, mdata(irr.mem_address)});
    end
    acc_v      = ~irr.p_waitrequest;
    wait_v     = irr.p_waitrequest;
    rdr_v      = irr.p_readdataready;
    rdata_v    = irr.p_readdata;
    fx_acc_v   = ~ifx.p_waitrequest;
    outst_v    = irr.outstanding;
    err_orph_v = irr.err_orphan;
    err_rdwr_v = irr.err_rdwr;
    mw_v       = irr.mem_write;
    mr_v       = irr.mem_read;
    maddr_v    = irr.mem_address;
    mwd_v      = irr.mem_writedata;
    obs_cyc    = cyc;
    @(posedge clk);
    #1;
    cyc++;
    irr.mem_waitrequest = force_stall || (stall_pct != 0 && int'($urandom_range(99)) < stall_pct);
    if (inject_orphan) begin
      irr.mem_readdataready = 1'b1;
      irr.mem_readdata      = 16'hDEAD;
      inject_orphan         = 0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      irr.mem_readdataready = 1'b1;
      irr.mem_readdata      = pend[0].data;
      void'(pend.pop_front());
    end else begin
      irr.mem_readdataready = 1'b0;
      irr.mem_readdata      = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irr.p_read  = '0;
    irr.p_write = '0;
    force_stall = 0;
    stall_pct   = 0;
    inject_orphan = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  int            acc_port[5];
  int            acc_cyc[5];
  int            t1_exp[5] = '{0, 1, 2, 3, 0};
  int            n_acc, fx_cnt, n_iss, n_rcv, maxo;
  logic [NP-1:0] fx_bad, other, hold;
  logic [NP-1:0] r_oh[2];
  logic [DW-1:0] rcv[6];
  int            r;

  initial begin
    rst = 1'b1;
    irr.p_address = '0; irr.p_byteenable = '0; irr.p_read = '0; irr.p_write = '0;
    irr.p_writedata = '0; irr.mem_waitrequest = 1'b0; irr.mem_readdata = '0;
    irr.mem_readdataready = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1;

    // Continuous writes from all ports: rotation on one instance, starvation on the other.
    do_reset();
    for (int i = 0; i < NP; i++) begin
      irr.p_address[i*AW +: AW]    = AW'(i * 256);
      irr.p_writedata[i*DW +: DW]  = DW'(16'hC000 + i);
      irr.p_byteenable[i*BW +: BW] = 2'b11;
    end
    irr.p_write = '1;
    n_acc = 0; fx_cnt = 0; fx_bad = '0;
    for (int k = 0; k < 5; k++) begin acc_port[k] = -1; acc_cyc[k] = 0; end
    for (int t = 0; t < 12; t++) begin
      tick();
      if (acc_v != '0 && n_acc < 5) begin
        acc_port[n_acc] = oh_idx(acc_v);
        acc_cyc[n_acc]  = obs_cyc;
        n_acc++;
      end
      if (fx_acc_v != '0) fx_cnt++;
      fx_bad |= fx_acc_v & 4'b1110;
    end
    irr.p_write = '0;
    check("t1_accepts", n_acc, 5);
    for (int k = 0; k < 5; k++) check("t1_port_order", acc_port[k], t1_exp[k]);
    for (int k = 1; k < 5; k++) check("t1_accept_gap", acc_cyc[k] - acc_cyc[k-1], 2);
    check("t2_fixed_accepts", fx_cnt, 6);
    check("t2_fixed_others_waiting", fx_bad, 4'b0000);

    // Port 2 streams six reads against a slow memory.
    do_reset();
    lat = 6; n_iss = 0; n_rcv = 0; maxo = 0; other = '0;
    irr.p_address[2*AW +: AW] = 20'h00010;
    irr.p_read[2] = 1'b1;
    for (int t = 0; t < 300 && n_rcv < 6; t++) begin
      tick();
      if (int'(outst_v) > maxo) maxo = int'(outst_v);
      other |= rdr_v & 4'b1011;
      if (rdr_v[2]) begin
        if (n_rcv < 6) rcv[n_rcv] = rdata_v;
        n_rcv++;
      end
      if (acc_v[2]) begin
        n_iss++;
        if (n_iss == 6) irr.p_read[2] = 1'b0;
        else irr.p_address[2*AW +: AW] = AW'(20'h00010 + n_iss);
      end
    end
    check("t3_max_outstanding", maxo, 4);
    check("t3_responses", n_rcv, 6);
    check("t3_no_other_port", other, 4'b0000);
    for (int k = 0; k < 6; k++) check("t3_data_order", rcv[k], mdata(AW'(20'h00010 + k)));

    // Two ports read concurrently; responses must be routed by issue order.
    do_reset();
    lat = 3; n_rcv = 0; r_oh[0] = '0; r_oh[1] = '0;
    irr.p_address[1*AW +: AW] = 20'h0000A;
    irr.p_address[3*AW +: AW] = 20'h0000B;
    irr.p_read = 4'b1010;
    for (int t = 0; t < 100 && n_rcv < 2; t++) begin
      tick();
      if (acc_v[1]) irr.p_read[1] = 1'b0;
      if (acc_v[3]) irr.p_read[3] = 1'b0;
      if (rdr_v != '0) begin
        if (n_rcv < 2) begin r_oh[n_rcv] = rdr_v; rcv[n_rcv] = rdata_v; end
        n_rcv++;
      end
    end
    check("t4_responses", n_rcv, 2);
    check("t4_first_port", r_oh[0], 4'b0010);
    check("t4_first_data", rcv[0], 16'h1111);
    check("t4_second_port", r_oh[1], 4'b1000);
    check("t4_second_data", rcv[1], 16'h3333);

    // Orphan response with nothing in flight.
    do_reset();
    inject_orphan = 1;
    tick();
    tick();
    check("t5_no_readdataready", rdr_v, 4'b0000);
    check("t5_err_before", err_orph_v, 1'b0);
    tick();
    check("t5_err_set", err_orph_v, 1'b1);
    repeat (4) tick();
    check("t5_err_sticky", err_orph_v, 1'b1);

    // Stalled write holds the bus stable, then reset mid-stall.
    do_reset();
    irr.p_address[0 +: AW]    = 20'h12345;
    irr.p_writedata[0 +: DW]  = 16'hBEEF;
    irr.p_byteenable[0 +: BW] = 2'b11;
    irr.p_write[0] = 1'b1;
    force_stall = 1;
    irr.mem_waitrequest = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_stall_write", mw_v, 1'b1);
      check("t6_stall_addr", maddr_v, 20'h12345);
      check("t6_stall_data", mwd_v, 16'hBEEF);
    end
    rst = 1'b1;
    tick();
    tick();
    check("t6_reset_write", mw_v, 1'b0);
    check("t6_reset_read", mr_v, 1'b0);
    check("t6_reset_wait", wait_v, 4'hF);
    check("t6_reset_outst", outst_v, 3'd0);
    check("t6_reset_rdr", rdr_v, 4'b0000);
    check("t6_reset_err_orphan", err_orph_v, 1'b0);
    check("t6_reset_err_rdwr", err_rdwr_v, 1'b0);
    rst = 1'b0;
    force_stall = 0;
    irr.p_write = '0;

    // Random traffic checked cycle by cycle against the model.
    do_reset();
    stall_pct = 30;
    hold = '0;
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < NP; i++) begin
        if (!hold[i] || acc_v[i] || $urandom_range(99) < 5) begin
          r = int'($urandom_range(99));
          irr.p_read[i]  = (r < 30) || (r >= 55 && r < 57);
          irr.p_write[i] = (r >= 30 && r < 57);
          hold[i] = (r < 57);
          irr.p_address[i*AW +: AW]    = AW'($urandom);
          irr.p_writedata[i*DW +: DW]  = DW'($urandom);
          irr.p_byteenable[i*BW +: BW] = BW'($urandom_range(3));
        end
      end
      lat = int'($urandom_range(8, 1));
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0;
    irr.p_read = '0;
    irr.p_write = '0;
    stall_pct = 0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
